// File: rtl/prime_trial_divider.sv
// Trial-division primality test: walks divisors 2,3,5,7,... up to the upstream bound
// using a restoring shift-subtract divider, then pulses done with the verdict.
module prime_trial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] test_number,
    input  logic [WIDTH-1:0] sqrt_limit,
    input  logic             enable_in,
    output logic             busy,
    output logic             done,
    output logic             is_prime
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] D_TWO = (WIDTH + 1)'(2);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, DIV, CHECK, DONE} state_t;

    state_t           state;
    logic             en_prev;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] l_q;
    logic [WIDTH:0]   d_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   d_next;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   l_ext;

    // r stays below d, and d is only ever below N, so the shifted remainder fits WIDTH+1 bits
    always_comb begin
        r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        d_next = (d_q == D_TWO) ? (WIDTH + 1)'(3) : d_q + D_TWO;
        n_ext  = {1'b0, n_q};
        l_ext  = {1'b0, l_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            en_prev  <= 1'b0;
            n_q      <= '0;
            l_q      <= '0;
            d_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            is_prime <= 1'b0;
        end else begin
            en_prev <= enable_in;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_in && !en_prev) begin
                        n_q      <= test_number;
                        l_q      <= sqrt_limit;
                        busy     <= 1'b1;
                        is_prime <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (n_q < WIDTH'(2)) begin
                        is_prime <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
                        is_prime <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        d_q   <= D_TWO;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    r_q   <= '0;
                    q_q   <= n_q;
                    cnt   <= CW'(WIDTH);
                    state <= DIV;
                end
                DIV: begin
                    r_q <= (r_sh >= d_q) ? r_sh - d_q : r_sh;
                    q_q <= {q_q[WIDTH-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= CHECK;
                end
                CHECK: begin
                    if (r_q == '0) begin
                        is_prime <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (d_next > l_ext || d_next >= n_ext) begin
                        is_prime <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        d_q   <= d_next;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
